// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among three sources.
// Each grant is sent as a 3-byte frame: source header, payload, terminator.
//
// state | meaning
// IDLE  | offer round-robin grant, accept one payload
// SEND  | wait for UART idle, then register the start strobe and byte
// GUARD | strobe low; busy ignored while the UART raises it
// WAIT  | wait for busy to fall, then next byte or end of frame
module uart_tx_scheduler #(
  parameter logic [7:0] HDR0 = 8'h4B,
  parameter logic [7:0] HDR1 = 8'h4C,
  parameter logic [7:0] HDR2 = 8'h53,
  parameter logic [7:0] TERM = 8'h0A
) (
  input  logic        FPGA_CLK1_50,
  input  logic        reset_n,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_data,
  output logic [2:0]  req_ready,
  input  logic        TxD_busy,
  output logic        TxD_start,
  output logic [7:0]  TxD_data,
  output logic        frame_active,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GUARD, S_WAIT} state_t;

  state_t     r_state;
  logic [1:0] r_rr;
  logic [1:0] r_src;
  logic [1:0] r_idx;
  logic [7:0] r_payload;
  logic       r_start;
  logic [7:0] r_data;
  logic       r_active;
  logic [7:0] r_count;

  logic [2:0] w_grant;
  logic [1:0] w_src;
  logic [7:0] w_win_data;
  logic [7:0] w_byte;
  logic       w_xfer;

  // Walk from lowest to highest priority so the last match (closest to rr) wins.
  always_comb begin
    w_grant = 3'b000;
    w_src   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      int j;
      j = (int'(r_rr) + k) % 3;
      if (req_valid[j]) begin
        w_grant = 3'b001 << j;
        w_src   = 2'(j);
      end
    end
  end

  always_comb begin
    case (w_src)
      2'd1:    w_win_data = req_data[15:8];
      2'd2:    w_win_data = req_data[23:16];
      default: w_win_data = req_data[7:0];
    endcase
  end

  always_comb begin
    case (r_idx)
      2'd0: begin
        case (r_src)
          2'd1:    w_byte = HDR1;
          2'd2:    w_byte = HDR2;
          default: w_byte = HDR0;
        endcase
      end
      2'd1:    w_byte = r_payload;
      default: w_byte = TERM;
    endcase
  end

  assign req_ready = (r_state == S_IDLE) ? w_grant : 3'b000;
  assign w_xfer    = |(req_valid & req_ready);

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_rr      <= 2'd0;
      r_src     <= 2'd0;
      r_idx     <= 2'd0;
      r_payload <= 8'h00;
      r_start   <= 1'b0;
      r_data    <= 8'h00;
      r_active  <= 1'b0;
      r_count   <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_payload <= w_win_data;
            r_src     <= w_src;
            r_rr      <= (w_src == 2'd2) ? 2'd0 : w_src + 2'd1;
            r_idx     <= 2'd0;
            r_active  <= 1'b1;
            r_state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (!TxD_busy) begin
            r_start <= 1'b1;
            r_data  <= w_byte;
            r_state <= S_GUARD;
          end
        end
        S_GUARD: begin
          r_start <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!TxD_busy) begin
            if (r_idx == 2'd2) begin
              r_count  <= r_count + 8'd1;
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign TxD_start    = r_start;
  assign TxD_data     = r_data;
  assign frame_active = r_active;
  assign frame_count  = r_count;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: frame-level model with a UART busy model and
// directed scenarios pinned by hand-computed byte sequences and cycle numbers.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req_valid = 3'b000;
  logic [23:0] req_data = 24'h0;
  logic [2:0]  req_ready;
  logic        TxD_busy = 1'b0;
  logic        TxD_start;
  logic [7:0]  TxD_data;
  logic        frame_active;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  uart_tx_scheduler dut (
    .FPGA_CLK1_50(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .TxD_busy(TxD_busy),
    .TxD_start(TxD_start),
    .TxD_data(TxD_data),
    .frame_active(frame_active),
    .frame_count(frame_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART model: busy rises the cycle after a strobe and lasts busy_len cycles.
  int   busy_len = 10;
  int   busy_cnt = 0;
  logic force_busy = 1'b0;
  logic saw_start = 1'b0;
  always @(negedge clk) saw_start = TxD_start;
  always @(posedge clk) begin
    #1;
    if (saw_start) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    saw_start = 1'b0;
    TxD_busy = force_busy || (busy_cnt > 0);
  end

  // Sources: source i keeps valid high until rem[i] payloads have been taken.
  int         rem[3] = '{0, 0, 0};
  logic [7:0] pay[3] = '{8'h00, 8'h00, 8'h00};
  logic [2:0] xfer_seen = 3'b000;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (xfer_seen[i] && rem[i] > 0) rem[i]--;
      req_valid[i] = (rem[i] > 0);
    end
    xfer_seen = 3'b000;
    req_data = {pay[2], pay[1], pay[0]};
  end

  // Frame-level model
  bit         m_idle = 1'b1;
  int         m_phase = 0;  // 0 none, 1 byte pending, 2 byte on the line
  int         m_from = 0;
  bit         m_due = 1'b0;
  logic [7:0] m_q[$];
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_count = 8'h00;
  logic [1:0] m_rr = 2'd0;
  logic [7:0] log_d[$];
  int         log_c[$];
  int         ready_cycles[3] = '{0, 0, 0};
  int         g_cyc = -1;
  logic       prev_start = 1'b0;
  logic       prev_busy = 1'b0;

  function automatic int winner(input logic [2:0] v, input logic [1:0] rr);
    for (int k = 0; k < 3; k++) begin
      int j;
      j = (int'(rr) + k) % 3;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [7:0] hdr(input int s);
    return (s == 0) ? 8'h4B : (s == 1) ? 8'h4C : 8'h53;
  endfunction

  always @(negedge clk) begin : cmp
    logic [2:0] exp_ready;
    int w;
    xfer_seen = req_valid & req_ready;
    if (!reset_n) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_TxD_start", 32'(TxD_start), 0);
      chk("rst_TxD_data", 32'(TxD_data), 0);
      chk("rst_frame_active", 32'(frame_active), 0);
      chk("rst_frame_count", 32'(frame_count), 0);
      m_idle = 1'b1; m_phase = 0; m_due = 1'b0; m_q.delete();
      m_last = 8'h00; m_count = 8'h00; m_rr = 2'd0;
      prev_start = 1'b0;
    end else begin
      exp_ready = 3'b000;
      w = -1;
      if (m_idle) begin
        w = winner(req_valid, m_rr);
        if (w >= 0) exp_ready = 3'b001 << w;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("frame_active", 32'(frame_active), 32'(!m_idle));
      chk("TxD_start", 32'(TxD_start), 32'(m_due));
      if (TxD_start) begin
        log_d.push_back(TxD_data);
        log_c.push_back(cyc);
        if (m_q.size() > 0) m_last = m_q.pop_front();
        chk("strobe_after_strobe", 32'(prev_start), 0);
        chk("strobe_after_busy", 32'(prev_busy), 0);
      end
      chk("TxD_data", 32'(TxD_data), 32'(m_last));
      chk("frame_count", 32'(frame_count), 32'(m_count));
      for (int i = 0; i < 3; i++) if (req_ready[i]) ready_cycles[i]++;
      if ((req_valid & req_ready) != 3'b000) g_cyc = cyc;
      prev_start = TxD_start;

      m_due = 1'b0;
      if (w >= 0) begin
        m_q.push_back(hdr(w));
        m_q.push_back(pay[w]);
        m_q.push_back(8'h0A);
        m_rr = 2'((w + 1) % 3);
        m_idle = 1'b0;
        m_phase = 1;
        m_from = cyc + 1;
      end else if (m_phase == 1 && cyc >= m_from && !TxD_busy) begin
        m_due = 1'b1;
        m_phase = 2;
        m_from = cyc + 2;
      end else if (m_phase == 2 && cyc >= m_from && !TxD_busy) begin
        if (m_q.size() > 0) begin
          m_phase = 1;
          m_from = cyc + 1;
        end else begin
          m_phase = 0;
          m_idle = 1'b1;
          m_count = m_count + 8'd1;
        end
      end
    end
    prev_busy = TxD_busy;
  end

  task automatic wait_done(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int n = 0; n < max_cycles && !done; n++) begin
      @(negedge clk); #1;
      if (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && m_idle && m_q.size() == 0)
        done = 1'b1;
    end
    chk("wait_done_timeout", 32'(done), 1);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    rem = '{0, 0, 0};
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic chk_bytes(input string name, input int base, input logic [7:0] exp[]);
    for (int k = 0; k < exp.size(); k++)
      chk(name, 32'((base + k < log_d.size()) ? log_d[base + k] : 8'hxx), 32'(exp[k]));
  endtask

  initial begin
    int base, c0, fall_c;
    bit got;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk); #1;

    // Single request
    ready_cycles = '{0, 0, 0};
    base = log_d.size();
    pay[0] = 8'h37; rem[0] = 1;
    wait_done(300);
    chk_bytes("single_bytes", base, '{8'h4B, 8'h37, 8'h0A});
    chk("single_ready_cycles", 32'(ready_cycles[0]), 1);
    chk("single_frame_count", 32'(frame_count), 1);

    // Round-robin with all three sources valid
    do_reset();
    base = log_d.size();
    pay[0] = 8'h31; pay[1] = 8'h30; pay[2] = 8'h41;
    rem = '{2, 1, 1};
    wait_done(1000);
    chk_bytes("rr_bytes", base, '{8'h4B, 8'h31, 8'h0A, 8'h4C, 8'h30, 8'h0A,
                                  8'h53, 8'h41, 8'h0A, 8'h4B, 8'h31, 8'h0A});
    chk("rr_frame_count", 32'(frame_count), 4);

    // Pointer skip: rr is now 1, only source 0 offers
    c0 = cyc;
    pay[0] = 8'h55; rem[0] = 1;
    wait_done(300);
    chk("skip_grant_cycle", 32'(g_cyc), 32'(c0 + 1));
    base = log_d.size();
    pay[0] = 8'h01; pay[1] = 8'h02;
    rem[0] = 1; rem[1] = 1;
    wait_done(600);
    chk_bytes("skip_rr_order", base, '{8'h4C, 8'h02, 8'h0A, 8'h4B, 8'h01, 8'h0A});

    // Busy stall before the header
    @(posedge clk); force_busy = 1'b1;
    base = log_d.size();
    pay[2] = 8'hC3; rem[2] = 1;
    repeat (50) @(posedge clk);
    force_busy = 1'b0;
    #2 fall_c = cyc;
    wait_done(300);
    chk("stall_header_cycle", 32'((log_c.size() > base) ? log_c[base] : -1), 32'(fall_c + 1));
    chk_bytes("stall_bytes", base, '{8'h53, 8'hC3, 8'h0A});

    // Reset after the payload strobe
    base = log_d.size();
    pay[1] = 8'h5A; rem[1] = 1;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk); #1;
      if (log_d.size() >= base + 2) got = 1'b1;
    end
    chk("midrst_payload_seen", 32'(got), 1);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_async_start", 32'(TxD_start), 0);
    chk("midrst_async_data", 32'(TxD_data), 0);
    chk("midrst_async_active", 32'(frame_active), 0);
    chk("midrst_async_count", 32'(frame_count), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst_no_terminator", 32'(log_d.size()), 32'(base + 2));
    base = log_d.size();
    pay[0] = 8'h66; rem[0] = 1;
    wait_done(300);
    chk_bytes("midrst_new_frame", base, '{8'h4B, 8'h66, 8'h0A});
    chk("midrst_frame_count", 32'(frame_count), 1);

    // Counter wrap over 256 back-to-back frames with zero-length busy
    do_reset();
    busy_len = 0;
    base = log_d.size();
    pay[0] = 8'h99; rem[0] = 256;
    wait_done(4000);
    chk("wrap_frame_count", 32'(frame_count), 0);
    chk("wrap_bytes_sent", 32'(log_d.size() - base), 768);
    chk_bytes("wrap_last_frame", log_d.size() - 3, '{8'h4B, 8'h99, 8'h0A});
    chk("wrap_frame_cycles", 32'((log_c.size() >= base + 4) ? log_c[base + 3] - log_c[base] : -1), 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
